// File: rtl/stack_seq_if.sv
// ----------------------------------------------------------------------------
// stack_seq_if
// Byte-wide memory bus between the stack sequencer (master) and memory
// (slave), using a req/ack handshake.
//   oAddr    master -> slave  byte address
//   oWrData  master -> slave  write byte
//   oWr      master -> slave  write request
//   oRd      master -> slave  read request
//   iAck     slave  -> master acknowledge for the current byte
//   iRdData  slave  -> master read byte, valid while iAck is high with oRd
// ----------------------------------------------------------------------------
interface stack_seq_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16
);
    logic [ADDRSIZE-1:0] oAddr;
    logic [DATASIZE-1:0] oWrData;
    logic                oWr;
    logic                oRd;
    logic                iAck;
    logic [DATASIZE-1:0] iRdData;

    modport master (
        output oAddr, oWrData, oWr, oRd,
        input  iAck, iRdData
    );

    modport slave (
        input  oAddr, oWrData, oWr, oRd,
        output iAck, iRdData
    );
endinterface

// File: rtl/stack_seq.sv
// ----------------------------------------------------------------------------
// stack_seq
// Stack-pointer sequencer. Owns SP and turns a word PUSH or POP request into
// two byte-wide bus cycles (high byte first on push, low byte first on pop),
// adjusting SP modulo 2^ADDRSIZE. Also loads SP directly.
//
// Ports:
//   iClk, iRst_n      clock, asynchronous active-low reset
//   iPush/iPop/iLoad  requests, sampled only in IDLE (load > push > pop)
//   iLoadVal          new SP value for a load
//   iWord             word to push, captured when the push starts
//   oWord             last popped word
//   oSP               live stack pointer
//   oBusy             high in every state except IDLE
//   oDone             one-cycle completion pulse
//   oFault            (STACK_FAULT_EN only) refused push/pop, valid with oDone
//   bus               memory bus master side (stack_seq_if.master)
//
// Build option: define STACK_FAULT_EN to refuse pushes with SP < 2 and pops
// with SP > 2^ADDRSIZE-3 instead of wrapping.
// ----------------------------------------------------------------------------
module stack_seq #(
    parameter int                  DATASIZE = 8,
    parameter int                  ADDRSIZE = 16,
    parameter logic [ADDRSIZE-1:0] SP_RESET = '0
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iPush,
    input  logic                  iPop,
    input  logic                  iLoad,
    input  logic [ADDRSIZE-1:0]   iLoadVal,
    input  logic [2*DATASIZE-1:0] iWord,
    output logic [2*DATASIZE-1:0] oWord,
    output logic [ADDRSIZE-1:0]   oSP,
    output logic                  oBusy,
    output logic                  oDone,
`ifdef STACK_FAULT_EN
    output logic                  oFault,
`endif
    stack_seq_if.master           bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_HI,
        S_PUSH_LO,
        S_POP_LO,
        S_POP_HI,
        S_DONE
    } state_t;

`ifdef STACK_FAULT_EN
    localparam logic [ADDRSIZE-1:0] PUSH_MIN = ADDRSIZE'(2);
    localparam logic [ADDRSIZE-1:0] POP_MAX  = {ADDRSIZE{1'b1}} - ADDRSIZE'(2);
`endif

    state_t                  state_q, state_d;
    logic [ADDRSIZE-1:0]     sp_q, sp_d;
    logic [2*DATASIZE-1:0]   push_word_q, push_word_d;
    logic [DATASIZE-1:0]     pop_lo_q, pop_lo_d;
    logic [2*DATASIZE-1:0]   pop_word_q, pop_word_d;
    logic                    fault_q, fault_d;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= S_IDLE;
            sp_q        <= SP_RESET;
            push_word_q <= '0;
            pop_lo_q    <= '0;
            pop_word_q  <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            push_word_q <= push_word_d;
            pop_lo_q    <= pop_lo_d;
            pop_word_q  <= pop_word_d;
            fault_q     <= fault_d;
        end
    end

    // SP only moves on an acknowledged byte, so an abort via reset never
    // leaves a half-applied update beyond the bytes already transferred.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        push_word_d = push_word_q;
        pop_lo_d    = pop_lo_q;
        pop_word_d  = pop_word_q;
        fault_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iLoad) begin
                    sp_d    = iLoadVal;
                    state_d = S_DONE;
                end else if (iPush) begin
`ifdef STACK_FAULT_EN
                    if (sp_q < PUSH_MIN) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else
`endif
                    begin
                        push_word_d = iWord;
                        state_d     = S_PUSH_HI;
                    end
                end else if (iPop) begin
`ifdef STACK_FAULT_EN
                    if (sp_q > POP_MAX) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else
`endif
                    begin
                        state_d = S_POP_LO;
                    end
                end
            end
            S_PUSH_HI: begin
                if (bus.iAck) begin
                    sp_d    = sp_q - ADDRSIZE'(1);
                    state_d = S_PUSH_LO;
                end
            end
            S_PUSH_LO: begin
                if (bus.iAck) begin
                    sp_d    = sp_q - ADDRSIZE'(1);
                    state_d = S_DONE;
                end
            end
            S_POP_LO: begin
                if (bus.iAck) begin
                    pop_lo_d = bus.iRdData;
                    sp_d     = sp_q + ADDRSIZE'(1);
                    state_d  = S_POP_HI;
                end
            end
            S_POP_HI: begin
                if (bus.iAck) begin
                    pop_word_d = {bus.iRdData, pop_lo_q};
                    sp_d       = sp_q + ADDRSIZE'(1);
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs decode from registered state and SP only; both hold while
    // a byte waits for iAck, keeping address and data stable.
    always_comb begin
        bus.oAddr   = '0;
        bus.oWrData = '0;
        bus.oWr     = 1'b0;
        bus.oRd     = 1'b0;
        case (state_q)
            S_PUSH_HI: begin
                bus.oAddr   = sp_q - ADDRSIZE'(1);
                bus.oWrData = push_word_q[2*DATASIZE-1:DATASIZE];
                bus.oWr     = 1'b1;
            end
            S_PUSH_LO: begin
                bus.oAddr   = sp_q - ADDRSIZE'(1);
                bus.oWrData = push_word_q[DATASIZE-1:0];
                bus.oWr     = 1'b1;
            end
            S_POP_LO, S_POP_HI: begin
                bus.oAddr = sp_q;
                bus.oRd   = 1'b1;
            end
            default: ;
        endcase
    end

    assign oWord = pop_word_q;
    assign oSP   = sp_q;
    assign oBusy = (state_q != S_IDLE);
    assign oDone = (state_q == S_DONE);
`ifdef STACK_FAULT_EN
    assign oFault = fault_q;
`endif

endmodule

// File: tb/tb_stack_seq.sv
// ----------------------------------------------------------------------------
// tb_stack_seq
// Self-checking bench for stack_seq: directed scenarios followed by random
// push/pop/load traffic against a word-level stack model with its own memory
// image. A memory responder with programmable wait states serves the bus.
// ----------------------------------------------------------------------------
module tb_stack_seq;

    localparam int          DW  = 8;
    localparam int          AW  = 16;
    localparam logic [15:0] SPR = 16'h0000;

    localparam int K_LOAD = 0;
    localparam int K_PUSH = 1;
    localparam int K_POP  = 2;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iPush, iPop, iLoad;
    logic [15:0] iLoadVal;
    logic [15:0] iWord;
    logic [15:0] oWord;
    logic [15:0] oSP;
    logic        oBusy, oDone;
`ifdef STACK_FAULT_EN
    logic        oFault;
`endif

    always #5 iClk = ~iClk;

    stack_seq_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

    stack_seq #(.DATASIZE(DW), .ADDRSIZE(AW), .SP_RESET(SPR)) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iPush    (iPush),
        .iPop     (iPop),
        .iLoad    (iLoad),
        .iLoadVal (iLoadVal),
        .iWord    (iWord),
        .oWord    (oWord),
        .oSP      (oSP),
        .oBusy    (oBusy),
        .oDone    (oDone),
`ifdef STACK_FAULT_EN
        .oFault   (oFault),
`endif
        .bus      (bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Memory served to the DUT (mem) and the model's own image (mm).
    logic [7:0] mem [0:65535];
    logic [7:0] mm  [0:65535];

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] sp;
    } ev_t;

    ev_t log_q[$];

    int          wait_cyc    = 0;
    int          waitcnt     = 0;
    bit          spurious_en = 1'b1;
    bit          holding     = 1'b0;
    logic [15:0] hold_addr;
    logic [7:0]  hold_data;

    // Memory responder: acks each byte after wait_cyc idle request cycles,
    // injects stray acks while no request is pending.
    initial begin
        ev_t e;
        bus.iAck    = 1'b0;
        bus.iRdData = '0;
        forever begin
            @(negedge iClk);
            check_val("wr_rd_exclusive", 32'(bus.oWr & bus.oRd), 32'd0);
            if (iRst_n && (bus.oWr || bus.oRd)) begin
                if (holding) begin
                    check_val("addr_stable", 32'(bus.oAddr), 32'(hold_addr));
                    check_val("wdata_stable", 32'(bus.oWrData), 32'(hold_data));
                end
                if (waitcnt >= wait_cyc) begin
                    bus.iAck = 1'b1;
                    if (bus.oWr) begin
                        mem[bus.oAddr] = bus.oWrData;
                        bus.iRdData    = 8'($urandom);
                    end else begin
                        bus.iRdData = mem[bus.oAddr];
                    end
                    e.wr   = bus.oWr;
                    e.addr = bus.oAddr;
                    e.data = bus.oWr ? bus.oWrData : mem[bus.oAddr];
                    e.sp   = oSP;
                    log_q.push_back(e);
                    waitcnt = 0;
                    holding = 1'b0;
                end else begin
                    bus.iAck    = 1'b0;
                    bus.iRdData = 8'($urandom);
                    waitcnt++;
                    holding   = 1'b1;
                    hold_addr = bus.oAddr;
                    hold_data = bus.oWrData;
                end
            end else begin
                bus.iAck    = spurious_en && ($urandom_range(0, 3) == 0);
                bus.iRdData = 8'($urandom);
                waitcnt     = 0;
                holding     = 1'b0;
            end
        end
    end

    // Word-level stack model.
    logic [15:0] msp;
    logic [15:0] mword;

    // Caller is at a negedge with the DUT idle. Returns at the negedge after
    // oDone, with the DUT idle again, so calls chain back to back.
    task automatic do_op(input int kind, input logic [15:0] val, input logic [15:0] word,
                         input int waitc, input bit simul, input bit req_in_done);
        ev_t  exp_q[$];
        ev_t  e;
        int   cyc;
        int   lat;
        bit   fault;
        logic [15:0] s;
        s     = msp;
        fault = 1'b0;
        lat   = 3 + 2 * waitc;
`ifdef STACK_FAULT_EN
        if (kind == K_PUSH && s < 16'd2)      fault = 1'b1;
        if (kind == K_POP  && s > 16'hFFFD)   fault = 1'b1;
`endif
        if (kind == K_LOAD) begin
            msp = val;
            lat = 1;
        end else if (fault) begin
            lat = 1;
        end else if (kind == K_PUSH) begin
            e.wr = 1'b1; e.addr = s - 16'd1; e.data = word[15:8]; e.sp = s;
            exp_q.push_back(e);
            e.wr = 1'b1; e.addr = s - 16'd2; e.data = word[7:0];  e.sp = s - 16'd1;
            exp_q.push_back(e);
            mm[s - 16'd1] = word[15:8];
            mm[s - 16'd2] = word[7:0];
            msp = s - 16'd2;
        end else begin
            e.wr = 1'b0; e.addr = s;         e.data = mm[s];         e.sp = s;
            exp_q.push_back(e);
            e.wr = 1'b0; e.addr = s + 16'd1; e.data = mm[s + 16'd1]; e.sp = s + 16'd1;
            exp_q.push_back(e);
            mword = {mm[s + 16'd1], mm[s]};
            msp   = s + 16'd2;
        end

        wait_cyc = waitc;
        log_q.delete();
        iLoad    = (kind == K_LOAD);
        iPush    = (kind == K_PUSH) || (simul && kind == K_LOAD);
        iPop     = (kind == K_POP)  || simul;
        iLoadVal = val;
        iWord    = word;
        @(negedge iClk);
        iLoad = 1'b0; iPush = 1'b0; iPop = 1'b0;
        iLoadVal = 16'($urandom);
        iWord    = 16'($urandom);
        check_val("busy_after_start", 32'(oBusy), 32'd1);
        cyc = 1;
        while (!oDone && cyc < 200) begin
            @(negedge iClk);
            cyc++;
        end
        check_val("done_seen", 32'(oDone), 32'd1);
        check_val("latency", 32'(cyc), 32'(lat));
        check_val("sp_at_done", 32'(oSP), 32'(msp));
        check_val("word_at_done", 32'(oWord), 32'(mword));
`ifdef STACK_FAULT_EN
        check_val("fault_at_done", 32'(oFault), 32'(fault));
`endif
        if (req_in_done) begin
            iPush = 1'b1;
            iPop  = 1'b1;
            iWord = 16'($urandom);
        end
        @(negedge iClk);
        iPush = 1'b0;
        iPop  = 1'b0;
        check_val("done_one_cycle", 32'(oDone), 32'd0);
        check_val("idle_after_done", 32'(oBusy), 32'd0);
`ifdef STACK_FAULT_EN
        check_val("fault_cleared", 32'(oFault), 32'd0);
`endif
        check_val("bus_cycle_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check_val("ev_dir",  32'(log_q[i].wr),   32'(exp_q[i].wr));
            check_val("ev_addr", 32'(log_q[i].addr), 32'(exp_q[i].addr));
            check_val("ev_data", 32'(log_q[i].data), 32'(exp_q[i].data));
            check_val("ev_sp",   32'(log_q[i].sp),   32'(exp_q[i].sp));
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          k;
        logic [15:0] lv;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            mm[i]  = mem[i];
        end
        iRst_n = 1'b0;
        iPush = 1'b0; iPop = 1'b0; iLoad = 1'b0;
        iLoadVal = '0; iWord = '0;
        msp   = SPR;
        mword = '0;
        repeat (2) @(negedge iClk);
        check_val("rst_sp",     32'(oSP), 32'(SPR));
        check_val("rst_word",   32'(oWord), 32'd0);
        check_val("rst_busy",   32'(oBusy), 32'd0);
        check_val("rst_done",   32'(oDone), 32'd0);
        check_val("rst_wr",     32'(bus.oWr), 32'd0);
        check_val("rst_rd",     32'(bus.oRd), 32'd0);
        check_val("rst_addr",   32'(bus.oAddr), 32'd0);
        check_val("rst_wrdata", 32'(bus.oWrData), 32'd0);
`ifdef STACK_FAULT_EN
        check_val("rst_fault",  32'(oFault), 32'd0);
`endif
        iRst_n = 1'b1;
        @(negedge iClk);

        // Load then push with zero wait states.
        do_op(K_LOAD, 16'h2000, 16'h0000, 0, 1'b0, 1'b0);
        do_op(K_PUSH, 16'h0000, 16'hBEEF, 0, 1'b0, 1'b0);
        check_val("mem_1fff", 32'(mem[16'h1FFF]), 32'hBE);
        check_val("mem_1ffe", 32'(mem[16'h1FFE]), 32'hEF);
        // Pop with three wait states per byte.
        do_op(K_POP, 16'h0000, 16'h0000, 3, 1'b0, 1'b0);
        check_val("pop_beef", 32'(oWord), 32'hBEEF);
        check_val("pop_sp",   32'(oSP), 32'h2000);
        // Simultaneous requests: load wins, then push over pop.
        do_op(K_LOAD, 16'h3000, 16'h0000, 0, 1'b1, 1'b0);
        do_op(K_PUSH, 16'h0000, 16'hA55A, 1, 1'b1, 1'b0);
        // Wrap-around (or refusal with the fault option).
        do_op(K_LOAD, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
        do_op(K_PUSH, 16'h0000, 16'h1234, 0, 1'b0, 1'b0);
        do_op(K_LOAD, 16'hFFFF, 16'h0000, 0, 1'b0, 1'b0);
        do_op(K_POP,  16'h0000, 16'h0000, 0, 1'b0, 1'b0);
        // Back-to-back push/pop with a request held during DONE.
        do_op(K_LOAD, 16'h8000, 16'h0000, 0, 1'b0, 1'b0);
        do_op(K_PUSH, 16'h0000, 16'hC0DE, 0, 1'b0, 1'b1);
        do_op(K_POP,  16'h0000, 16'h0000, 0, 1'b0, 1'b0);
        check_val("b2b_word", 32'(oWord), 32'hC0DE);
        check_val("b2b_sp",   32'(oSP), 32'h8000);

        // Asynchronous reset in the middle of a pop (POP_HI).
        do_op(K_LOAD, 16'h4000, 16'h0000, 0, 1'b0, 1'b0);
        wait_cyc = 3;
        log_q.delete();
        iPop = 1'b1;
        @(negedge iClk);
        iPop = 1'b0;
        n = 0;
        while (log_q.size() < 1 && n < 50) begin
            @(negedge iClk);
            n++;
        end
        check_val("rst_pop_first_byte", 32'(log_q.size()), 32'd1);
        @(negedge iClk);
        check_val("rst_pop_reading", 32'(bus.oRd), 32'd1);
        #2 iRst_n = 1'b0;
        #1;
        check_val("arst_sp",   32'(oSP), 32'(SPR));
        check_val("arst_rd",   32'(bus.oRd), 32'd0);
        check_val("arst_busy", 32'(oBusy), 32'd0);
        check_val("arst_word", 32'(oWord), 32'd0);
        check_val("arst_addr", 32'(bus.oAddr), 32'd0);
        msp   = SPR;
        mword = '0;
        @(negedge iClk);
        iRst_n = 1'b1;
        @(negedge iClk);

        // Random traffic, biased towards the SP boundaries.
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            case ($urandom_range(0, 5))
                0:       lv = 16'h0000;
                1:       lv = 16'h0001;
                2:       lv = 16'hFFFE;
                3:       lv = 16'hFFFF;
                default: lv = 16'($urandom);
            endcase
            do_op((k < 2) ? K_LOAD : (k < 6) ? K_PUSH : K_POP, lv, 16'($urandom),
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
